// File: rtl/bs_dot_accumulator.sv
// bs_dot_accumulator: sums VEC_LEN signed MAC products into a saturating dot product held in a valid/ready output register
module bs_dot_accumulator #(
    parameter int VEC_LEN = 8,
    parameter int ACC_W   = 20,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             prod_valid,
    input  logic [15:0]      prod_data,
    output logic             prod_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] vec_cnt
);
    logic [ACC_W-1:0] acc_q, acc_d, data_q, data_d, sat;
    logic [ACC_W:0]   sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d, valid_q, valid_d, oovf_q, oovf_d;
    logic             ovf, last, fire;
    assign sum        = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-15){prod_data[15]}}, prod_data};
    assign ovf        = sum[ACC_W] ^ sum[ACC_W-1];
    assign sat        = ovf ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
    assign last       = cnt_q == CNT_W'(VEC_LEN - 1);
    assign prod_ready = ~clr & ~(last & valid_q & ~out_ready);
    assign fire       = prod_valid & prod_ready;
    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_ovf    = oovf_q;
    assign vec_cnt    = cnt_q;
    // next state: clear, final accept (publish result and restart) or plain accumulate
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        valid_d  = valid_q & ~out_ready;
        data_d   = data_q;
        oovf_d   = oovf_q;
        if (clr) begin
            acc_d    = '0;
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (fire && last) begin
            acc_d    = '0;
            cnt_d    = '0;
            sticky_d = 1'b0;
            valid_d  = 1'b1;
            data_d   = sat;
            oovf_d   = sticky_q | ovf;
        end else if (fire) begin
            acc_d    = sat;
            cnt_d    = cnt_q + 1'b1;
            sticky_d = sticky_q | ovf;
        end
    end
    // state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            oovf_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            oovf_q   <= oovf_d;
        end
    end
endmodule

// File: tb/tb_bs_dot_accumulator.sv
// tb_bs_dot_accumulator: table-driven and scoreboarded checks of the dot-product accumulator
module tb_bs_dot_accumulator;
    logic clk = 0, rstn = 1;
    logic clr_a = 0, pv_a = 0, or_a = 1, clr_b = 0, pv_b = 0, or_b = 1;
    logic [15:0] pd_a = 0, pd_b = 0;
    logic pr_a, ov_a, oo_a, pr_b, ov_b, oo_b;
    logic [19:0] od_a;
    logic [16:0] od_b;
    logic [7:0] vc_a;
    logic [1:0] vc_b;
    int tests = 0, fails = 0;
    bit rs_a, rs_b;
    typedef struct {longint d; bit o;} res_t;
    res_t q_a[$], q_b[$];
    typedef struct {logic [15:0] p[8]; longint exp; bit ovf;} vec_t;
    vec_t tbl[5];

    bs_dot_accumulator dut_a (
        .clk(clk), .rstn(rstn), .clr(clr_a), .prod_valid(pv_a), .prod_data(pd_a),
        .prod_ready(pr_a), .out_valid(ov_a), .out_ready(or_a), .out_data(od_a),
        .out_ovf(oo_a), .vec_cnt(vc_a)
    );
    bs_dot_accumulator #(.VEC_LEN(4), .ACC_W(17), .CNT_W(2)) dut_b (
        .clk(clk), .rstn(rstn), .clr(clr_b), .prod_valid(pv_b), .prod_data(pd_b),
        .prod_ready(pr_b), .out_valid(ov_b), .out_ready(or_b), .out_data(od_b),
        .out_ovf(oo_b), .vec_cnt(vc_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_chk(input bit b);
        res_t r;
        if ((b ? q_b.size() : q_a.size()) == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: result handshake with nothing expected at %0t", b ? "res_b" : "res_a", $time);
        end else begin
            r = b ? q_b.pop_front() : q_a.pop_front();
            chk(b ? "res_b_data" : "res_a_data", b ? longint'($signed(od_b)) : longint'($signed(od_a)), r.d);
            chk(b ? "res_b_ovf" : "res_a_ovf", b ? longint'(oo_b) : longint'(oo_a), longint'(r.o));
        end
    endtask

    // one cycle: sample on the falling edge, return just after the rising edge
    task automatic tick();
        @(negedge clk);
        rs_a = pv_a & pr_a;
        rs_b = pv_b & pr_b;
        if (ov_a && or_a) pop_chk(0);
        if (ov_b && or_b) pop_chk(1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit b, input logic [15:0] v);
        bit acc = 0;
        if (b) begin pv_b = 1; pd_b = v; end else begin pv_a = 1; pd_a = v; end
        for (int k = 0; k < 20 && !acc; k++) begin
            tick();
            acc = b ? rs_b : rs_a;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got no accept, expected accept of %0d", $signed(v));
        end
        pv_a = 0;
        pv_b = 0;
    endtask

    task automatic push(input bit b, input longint d, input bit o);
        res_t r;
        r.d = d;
        r.o = o;
        if (b) q_b.push_back(r); else q_a.push_back(r);
    endtask

    initial begin
        for (int j = 0; j < 8; j++) begin
            tbl[0].p[j] = 16'd1000;
            tbl[2].p[j] = 16'h7FFF;
            tbl[3].p[j] = 16'h8000;
            tbl[4].p[j] = 16'((j % 2) ? -(100 * (j + 1)) : 100 * (j + 1));
            tbl[1].p[j] = 16'd0;
        end
        tbl[1].p[0] = -16'sd32640;
        tbl[1].p[1] = 16'd32385;
        tbl[1].p[2] = -16'sd1;
        tbl[1].p[3] = 16'd256;
        tbl[0].exp = 8000;    tbl[0].ovf = 0;
        tbl[1].exp = 0;       tbl[1].ovf = 0;
        tbl[2].exp = 262136;  tbl[2].ovf = 0;
        tbl[3].exp = -262144; tbl[3].ovf = 0;
        tbl[4].exp = -400;    tbl[4].ovf = 0;

        #1 rstn = 0;
        #1;
        chk("rst_out_valid", ov_a, 0);
        chk("rst_out_data", od_a, 0);
        chk("rst_out_ovf", oo_a, 0);
        chk("rst_vec_cnt", vc_a, 0);
        chk("rst_prod_ready", pr_a, 1);
        tick();
        tick();
        rstn = 1;

        for (int i = 0; i < 5; i++) begin
            push(0, tbl[i].exp, tbl[i].ovf);
            for (int j = 0; j < 8; j++) begin
                send(0, tbl[i].p[j]);
                chk("vec_cnt_step", vc_a, (j + 1) % 8);
            end
            chk("valid_after_final", ov_a, 1);
        end
        tick();

        push(1, 65535, 1);
        push(1, 4, 0);
        for (int j = 0; j < 4; j++) send(1, 16'd32385);
        chk("sat_valid", ov_b, 1);
        for (int j = 0; j < 4; j++) send(1, 16'd1);
        tick();
        chk("sat_vec_cnt", vc_b, 0);

        or_a = 0;
        push(0, 8, 0);
        push(0, 8, 0);
        for (int j = 0; j < 8; j++) send(0, 16'd1);
        chk("bp_first_valid", ov_a, 1);
        for (int j = 0; j < 7; j++) begin
            send(0, 16'd1);
            chk("bp_hold_data", $signed(od_a), 8);
        end
        pv_a = 1;
        pd_a = 16'd1;
        #1 chk("bp_stall_ready", pr_a, 0);
        tick();
        tick();
        chk("bp_stall_cnt", vc_a, 7);
        chk("bp_stall_data", $signed(od_a), 8);
        chk("bp_stall_valid", ov_a, 1);
        or_a = 1;
        #1 chk("bp_release_ready", pr_a, 1);
        tick();
        pv_a = 0;
        chk("bp_nobubble_valid", ov_a, 1);
        chk("bp_new_data", $signed(od_a), 8);
        chk("bp_cnt_wrap", vc_a, 0);
        tick();
        chk("bp_drained", ov_a, 0);

        for (int j = 0; j < 3; j++) send(0, 16'd5);
        chk("clr_pre_cnt", vc_a, 3);
        clr_a = 1;
        pv_a = 1;
        pd_a = 16'd5;
        #1 chk("clr_ready_low", pr_a, 0);
        tick();
        clr_a = 0;
        pv_a = 0;
        chk("clr_cnt", vc_a, 0);
        push(0, 16, 0);
        for (int j = 0; j < 8; j++) send(0, 16'd2);
        tick();

        or_a = 0;
        for (int j = 0; j < 8; j++) send(0, 16'd3);
        chk("rst_pre_valid", ov_a, 1);
        chk("rst_pre_data", $signed(od_a), 24);
        for (int j = 0; j < 3; j++) send(0, 16'd3);
        #2 rstn = 0;
        #1;
        chk("arst_valid", ov_a, 0);
        chk("arst_data", od_a, 0);
        chk("arst_ovf", oo_a, 0);
        chk("arst_cnt", vc_a, 0);
        tick();
        rstn = 1;
        or_a = 1;
        push(0, 56, 0);
        for (int j = 0; j < 8; j++) send(0, 16'd7);
        tick();
        tick();
        chk("q_a_empty", q_a.size(), 0);
        chk("q_b_empty", q_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bs_dot_accumulator.md
Name: bs_dot_accumulator

Overview:
Downstream stage of the bit-serial MAC unit. Consumes the signed 16-bit products the MAC emits, one per completed weight word, and sums VEC_LEN of them into one saturating dot-product result. Each result is presented on a single-entry valid/ready output register. The block back-pressures the MAC only when a vector completes while the previous result is still pending.

Parameters:
VEC_LEN, 8, number of products summed per dot-product result; legal range 1..256.
ACC_W, 20, accumulator and result width in bits, signed two's complement; minimum 17.
CNT_W, 8, width of the product counter; must satisfy 2^CNT_W >= VEC_LEN.

Ports:
clk  input  1  clock, rising edge.
rstn  input  1  reset, asynchronous, active-low.
clr  input  1  synchronous clear of the in-progress vector.
prod_valid  input  1  one-cycle strobe: prod_data holds a finished MAC product.
prod_data  input  16  signed product, two's complement.
prod_ready  output  1  block can accept prod_data this cycle.
out_valid  output  1  out_data and out_ovf hold a completed result.
out_ready  input  1  consumer accepts the result.
out_data  output  ACC_W  signed dot-product result.
out_ovf  output  1  saturation occurred at least once within this result's vector.
vec_cnt  output  CNT_W  number of products accepted in the current vector.

Behaviour:
- Reset (rstn low, asynchronous): acc=0, vec_cnt=0, ovf_sticky=0, out_valid=0, out_data=0, out_ovf=0. Reset mid-vector discards the partial sum and any pending result.
- Accept: acc_fire = prod_valid & prod_ready.
- prod_ready = ~clr & ~(vec_cnt==VEC_LEN-1 & out_valid & ~out_ready). Combinational; the stall occurs only on the final product of a vector while the output is occupied and not draining.
- Add rule:
  - sum = acc + sign-extended prod_data, computed at ACC_W+1 bits.
  - If sum > 2^(ACC_W-1)-1, clamp to the maximum; if sum < -2^(ACC_W-1), clamp to the minimum.
  - Either clamp sets ovf_sticky.
- Non-final accept (vec_cnt < VEC_LEN-1): acc <= clamped sum; vec_cnt++.
- Final accept (vec_cnt == VEC_LEN-1):
  - out_data <= clamped sum; out_ovf <= ovf_sticky | (overflow this add); out_valid <= 1.
  - In the same edge, acc <= 0, vec_cnt <= 0, ovf_sticky <= 0.
  - Result is visible one cycle after the accepting edge.
- VEC_LEN=1: every accept is a final accept.
- Output handshake: out_valid & out_ready clears out_valid at the next edge unless a final accept occurs in the same cycle. In that case out_valid stays 1 and the new result replaces the old one with no bubble.
- While out_valid=1 and out_ready=0:
  - out_data and out_ovf remain stable.
  - Accumulation of the next vector continues up to VEC_LEN-1 products.
- prod_valid while prod_ready=0: the product is ignored, not queued. The upstream MAC must hold its enable low, so done re-asserts only after prod_ready returns.
- clr: has priority over prod_valid in the same cycle (product dropped; prod_ready is 0). Sets acc=0, vec_cnt=0, ovf_sticky=0. Output register, out_valid and the output handshake are unaffected.
- State: two implicit states, ACCUM (prod_ready=1) and STALL (final product pending with the output full). STALL is left the cycle out_ready=1 or out_valid=0.
- No combinational path from prod_data to any output. The only combinational input→output path is out_ready/clr → prod_ready.

Test Plan:
- Reset, then defaults: 8 products of +1000 (0x03E8) on consecutive cycles with out_ready=1 -> out_valid high one cycle after the 8th accept, out_data=8000, out_ovf=0, vec_cnt back to 0.
- Signed mix: products -32640, 32385, -1, 256, then 4×0 -> out_data=-32640+32385-1+256=0, out_ovf=0.
- Saturation with VEC_LEN=4, ACC_W=17: 4×32385 -> after 3rd add, sum 97155 clamps to 65535; out_data=65535, out_ovf=1. Next vector of 4×1 -> out_data=4, out_ovf=0 (sticky cleared).
- Back-pressure: out_ready=0 held, two full vectors of +1 fed -> first result 8 held stable. prod_ready drops with vec_cnt=7 on the second vector. Raise out_ready -> the 8th product is accepted in that cycle and out_data becomes 8 with out_valid continuously high.
- clr mid-vector: 3 products of +5, then clr asserted together with prod_valid of +5 -> vec_cnt=0, product dropped. Next 8 products of +2 -> out_data=16.
- Async reset mid-vector with out_valid=1 -> all outputs 0 immediately, prior to the next clk edge. Post-reset vector sums from zero.
